// File: rtl/poly_hit_sequencer_if.sv
// Query/issue/result bundle between the hit sequencer and its neighbours.
// The slave modport is the sequencer's view; master is the driver/consumer side.
interface poly_hit_sequencer_if #(
  parameter int WORLD_BITS = 32,
  parameter int MAX_POLYS  = 16
);
  localparam int NUM_W = $clog2(MAX_POLYS + 1);
  localparam int IDX_W = $clog2(MAX_POLYS);

  logic                         query_valid_in;
  logic                         query_ready_out;
  logic signed [WORLD_BITS-1:0] x_in;
  logic signed [WORLD_BITS-1:0] y_in;
  logic [NUM_W-1:0]             num_polys_in;
  logic signed [WORLD_BITS-1:0] px_out;
  logic signed [WORLD_BITS-1:0] py_out;
  logic [IDX_W-1:0]             poly_idx_out;
  logic                         poly_valid_out;
  logic                         dp_result_in;
  logic                         res_valid_out;
  logic                         res_ready_in;
  logic                         hit_out;
  logic [IDX_W-1:0]             hit_idx_out;
  logic                         busy_out;

  modport slave (
    input  query_valid_in, x_in, y_in, num_polys_in, dp_result_in, res_ready_in,
    output query_ready_out, px_out, py_out, poly_idx_out, poly_valid_out,
           res_valid_out, hit_out, hit_idx_out, busy_out
  );

  modport master (
    output query_valid_in, x_in, y_in, num_polys_in, dp_result_in, res_ready_in,
    input  query_ready_out, px_out, py_out, poly_idx_out, poly_valid_out,
           res_valid_out, hit_out, hit_idx_out, busy_out
  );
endinterface

// File: rtl/poly_hit_sequencer.sv
// Issues polygon indices for one query point to a pipelined point-in-polygon datapath
// and folds the returning inside/outside bits into a first-hit result.
module poly_hit_sequencer #(
  parameter int WORLD_BITS  = 32,
  parameter int MAX_POLYS   = 16,
  parameter int PIP_LATENCY = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  poly_hit_sequencer_if.slave   bus
);
  localparam int NUM_W = $clog2(MAX_POLYS + 1);
  localparam int IDX_W = $clog2(MAX_POLYS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                       state_reg;
  logic                         query_ready_reg;
  logic                         busy_reg;
  logic                         poly_valid_reg;
  logic                         res_valid_reg;
  logic                         hit_reg;
  logic                         acc_hit_reg;
  logic [IDX_W-1:0]             poly_idx_reg;
  logic [IDX_W-1:0]             last_idx_reg;
  logic [IDX_W-1:0]             hit_idx_reg;
  logic [IDX_W-1:0]             acc_idx_reg;
  logic signed [WORLD_BITS-1:0] px_reg;
  logic signed [WORLD_BITS-1:0] py_reg;
  logic [PIP_LATENCY-1:0]       trk_v_reg;
  logic [IDX_W-1:0]             trk_idx_reg [PIP_LATENCY];

  logic [NUM_W-1:0]             n_clamped;
  logic                         emerge_v;
  logic                         emerge_hit;
  logic [IDX_W-1:0]             emerge_idx;

  assign n_clamped  = (bus.num_polys_in > NUM_W'(MAX_POLYS)) ? NUM_W'(MAX_POLYS)
                                                             : bus.num_polys_in;
  assign emerge_v   = trk_v_reg[PIP_LATENCY-1];
  assign emerge_idx = trk_idx_reg[PIP_LATENCY-1];
  assign emerge_hit = emerge_v & bus.dp_result_in;

  // Mirrors the datapath pipeline so each returning bit is paired with its index.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      trk_v_reg <= '0;
      for (int i = 0; i < PIP_LATENCY; i++) trk_idx_reg[i] <= '0;
    end else begin
      trk_v_reg[0]   <= poly_valid_reg;
      trk_idx_reg[0] <= poly_idx_reg;
      for (int i = 1; i < PIP_LATENCY; i++) begin
        trk_v_reg[i]   <= trk_v_reg[i-1];
        trk_idx_reg[i] <= trk_idx_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg       <= IDLE;
      query_ready_reg <= 1'b0;
      busy_reg        <= 1'b0;
      poly_valid_reg  <= 1'b0;
      res_valid_reg   <= 1'b0;
      hit_reg         <= 1'b0;
      acc_hit_reg     <= 1'b0;
      poly_idx_reg    <= '0;
      last_idx_reg    <= '0;
      hit_idx_reg     <= '0;
      acc_idx_reg     <= '0;
      px_reg          <= '0;
      py_reg          <= '0;
    end else begin
      // Only the first hit records its index; later hits just keep the flag set.
      if (emerge_hit && !acc_hit_reg) begin
        acc_hit_reg <= 1'b1;
        acc_idx_reg <= emerge_idx;
      end
      case (state_reg)
        IDLE: begin
          query_ready_reg <= 1'b1;
          if (bus.query_valid_in && query_ready_reg) begin
            px_reg          <= bus.x_in;
            py_reg          <= bus.y_in;
            acc_hit_reg     <= 1'b0;
            acc_idx_reg     <= '0;
            query_ready_reg <= 1'b0;
            busy_reg        <= 1'b1;
            if (n_clamped == '0) begin
              state_reg     <= DONE;
              res_valid_reg <= 1'b1;
              hit_reg       <= 1'b0;
              hit_idx_reg   <= '0;
            end else begin
              state_reg      <= ISSUE;
              poly_valid_reg <= 1'b1;
              poly_idx_reg   <= '0;
              last_idx_reg   <= IDX_W'(n_clamped - NUM_W'(1));
            end
          end
        end
        ISSUE: begin
          if (poly_idx_reg == last_idx_reg) begin
            poly_valid_reg <= 1'b0;
            state_reg      <= DRAIN;
          end else begin
            poly_idx_reg <= poly_idx_reg + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (emerge_v && (emerge_idx == last_idx_reg)) begin
            state_reg     <= DONE;
            res_valid_reg <= 1'b1;
            hit_reg       <= acc_hit_reg | emerge_hit;
            hit_idx_reg   <= acc_hit_reg ? acc_idx_reg : (emerge_hit ? emerge_idx : '0);
          end
        end
        DONE: begin
          if (bus.res_ready_in) begin
            res_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            query_ready_reg <= 1'b1;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.query_ready_out = query_ready_reg;
  assign bus.px_out          = px_reg;
  assign bus.py_out          = py_reg;
  assign bus.poly_idx_out    = poly_idx_reg;
  assign bus.poly_valid_out  = poly_valid_reg;
  assign bus.res_valid_out   = res_valid_reg;
  assign bus.hit_out         = hit_reg;
  assign bus.hit_idx_out     = hit_idx_reg;
  assign bus.busy_out        = busy_reg;
endmodule

// File: tb/tb_poly_hit_sequencer.sv
// Scoreboard bench for poly_hit_sequencer: a delay-line datapath model answers the
// issue strobes from a per-query mask and a monitor checks every returned result.
module tb_poly_hit_sequencer;
  localparam int WB = 32;
  localparam int MP = 16;
  localparam int L  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_hit_sequencer_if #(.WORLD_BITS(WB), .MAX_POLYS(MP)) bus();

  poly_hit_sequencer #(.WORLD_BITS(WB), .MAX_POLYS(MP), .PIP_LATENCY(L)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic                 hit;
    logic [3:0]           idx;
    int                   n;
    logic signed [WB-1:0] x;
    logic signed [WB-1:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [15:0] mask_cur = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Datapath model: answers an issued index L cycles later; drives 1 on idle cycles.
  logic [L-1:0] dp_v;
  logic [3:0]   dp_idx [L];
  always @(posedge clk) begin
    if (!rst_n) begin
      dp_v <= '0;
    end else begin
      dp_v[0]   <= bus.poly_valid_out;
      dp_idx[0] <= bus.poly_idx_out;
      for (int i = 1; i < L; i++) begin
        dp_v[i]   <= dp_v[i-1];
        dp_idx[i] <= dp_idx[i-1];
      end
    end
  end
  assign bus.dp_result_in = dp_v[L-1] ? mask_cur[dp_idx[L-1]] : 1'b1;

  // Monitor: strobe ordering, result scoreboard, latency and DONE stability.
  logic rdy_prev = 1'b0;
  logic res_prev = 1'b0;
  int   strobe_cnt = 0;
  int   acc_cyc = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      rdy_prev = 1'b0;
      res_prev = 1'b0;
    end else begin
      if (rdy_prev && !bus.query_ready_out) begin
        acc_cyc    = cyc;
        strobe_cnt = 0;
      end
      if (bus.poly_valid_out) begin
        check_val("strobe_idx", 64'(bus.poly_idx_out), 64'(strobe_cnt));
        strobe_cnt++;
      end
      if (bus.res_valid_out && !res_prev) begin
        check_val("result_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check_val("hit", 64'(bus.hit_out), 64'(cur.hit));
          check_val("hit_idx", 64'(bus.hit_idx_out), 64'(cur.idx));
          check_val("strobe_count", 64'(strobe_cnt), 64'(cur.n));
          check_val("latency", 64'(cyc - acc_cyc), 64'((cur.n == 0) ? 0 : cur.n + L));
          check_val("px", 64'(bus.px_out), 64'(cur.x));
          check_val("py", 64'(bus.py_out), 64'(cur.y));
          $display("result n=%0d hit=%0b idx=%0d", cur.n, bus.hit_out, bus.hit_idx_out);
        end
      end else if (bus.res_valid_out) begin
        check_val("hit_stable", 64'(bus.hit_out), 64'(cur.hit));
        check_val("hit_idx_stable", 64'(bus.hit_idx_out), 64'(cur.idx));
      end
      if (bus.res_valid_out) check_val("ready_in_done", 64'(bus.query_ready_out), 64'(0));
      rdy_prev = bus.query_ready_out;
      res_prev = bus.res_valid_out;
    end
  end

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_ready"}, 64'(bus.query_ready_out), 64'(0));
    check_val({tag, "_pvalid"}, 64'(bus.poly_valid_out), 64'(0));
    check_val({tag, "_pidx"}, 64'(bus.poly_idx_out), 64'(0));
    check_val({tag, "_rvalid"}, 64'(bus.res_valid_out), 64'(0));
    check_val({tag, "_busy"}, 64'(bus.busy_out), 64'(0));
    check_val({tag, "_hit"}, 64'(bus.hit_out), 64'(0));
    check_val({tag, "_hitidx"}, 64'(bus.hit_idx_out), 64'(0));
    check_val({tag, "_px"}, 64'(bus.px_out), 64'(0));
    check_val({tag, "_py"}, 64'(bus.py_out), 64'(0));
  endtask

  task automatic wait_accept();
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (bus.query_ready_out) begin
        got = 1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    check_val("accept_timeout", 64'(got), 64'(1));
    bus.query_valid_in = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge after the result handshake.
  task automatic run_query(input int num, input logic [15:0] mask, input int hold);
    exp_t e;
    bit   got = 0;
    e.n   = (num > MP) ? MP : num;
    e.hit = 1'b0;
    e.idx = '0;
    for (int i = 0; i < e.n; i++)
      if (mask[i] && !e.hit) begin
        e.hit = 1'b1;
        e.idx = 4'(i);
      end
    e.x = $urandom;
    e.y = $urandom;
    mask_cur = mask;
    exp_q.push_back(e);
    bus.x_in = e.x;
    bus.y_in = e.y;
    bus.num_polys_in = num[4:0];
    bus.query_valid_in = 1'b1;
    wait_accept();
    bus.x_in = ~e.x;
    bus.y_in = ~e.y;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.res_valid_out) got = 1;
      else @(negedge clk);
    end
    check_val("res_timeout", 64'(got), 64'(1));
    for (int i = 0; i < hold; i++) begin
      check_val("ready_held_off", 64'(bus.query_ready_out), 64'(0));
      check_val("px_hold", 64'(bus.px_out), 64'(e.x));
      bus.query_valid_in = 1'b1;
      @(negedge clk);
    end
    bus.query_valid_in = 1'b0;
    bus.res_ready_in = 1'b1;
    @(negedge clk);
    bus.res_ready_in = 1'b0;
    check_val("res_cleared", 64'(bus.res_valid_out), 64'(0));
    check_val("busy_cleared", 64'(bus.busy_out), 64'(0));
    check_val("ready_after_done", 64'(bus.query_ready_out), 64'(1));
    $display("query num=%0d mask=%04h hold=%0d exp_hit=%0b exp_idx=%0d", num, mask, hold, e.hit, e.idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.query_valid_in = 1'b0;
    bus.res_ready_in   = 1'b0;
    bus.x_in           = '0;
    bus.y_in           = '0;
    bus.num_polys_in   = '0;
    repeat (2) @(negedge clk);
    check_reset_outs("rst");
    rst_n = 1'b1;
    #1;
    check_val("ready_before_edge", 64'(bus.query_ready_out), 64'(0));
    @(negedge clk);
    check_val("ready_first_edge", 64'(bus.query_ready_out), 64'(1));

    run_query(3, 16'h0000, 0);
    run_query(5, 16'h0014, 0);
    run_query(0, 16'hffff, 0);
    run_query(31, 16'h8000, 0);
    run_query(4, 16'h0008, 10);
    for (int k = 0; k < 6; k++)
      run_query($urandom_range(0, 20), 16'($urandom), $urandom_range(0, 3));

    // Abort a query in DRAIN while the datapath reports hits.
    mask_cur = 16'hffff;
    bus.num_polys_in = 5'd2;
    bus.query_valid_in = 1'b1;
    wait_accept();
    repeat (2) @(negedge clk);
    check_val("in_drain_busy", 64'(bus.busy_out), 64'(1));
    check_val("in_drain_pvalid", 64'(bus.poly_valid_out), 64'(0));
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_val("no_aborted_result", 64'(bus.res_valid_out), 64'(0));
    end
    $display("aborted query in DRAIN");
    run_query(1, 16'h0000, 0);

    check_val("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/poly_hit_sequencer.md
POLY_HIT_SEQUENCER -- requirements
Module: poly_hit_sequencer

Interface
REQ-001 SHALL have parameter WORLD_BITS, default 32, signed world-coordinate width.
REQ-002 SHALL have parameter MAX_POLYS, default 16, maximum polygons scanned per query.
REQ-003 SHALL have parameter PIP_LATENCY, default 4, cycles from poly_valid_out to matching dp_result_in (legal range 1..8).
REQ-004 SHALL have port clk_in  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port query_valid_in  input  1  query point offered.
REQ-007 SHALL have port query_ready_out  output  1  sequencer accepts a query.
REQ-008 SHALL have port x_in  input  WORLD_BITS signed  query x.
REQ-009 SHALL have port y_in  input  WORLD_BITS signed  query y.
REQ-010 SHALL have port num_polys_in  input  $clog2(MAX_POLYS+1)  polygons to scan.
REQ-011 SHALL have port px_out  output  WORLD_BITS signed  latched x to point-in-polygon datapath.
REQ-012 SHALL have port py_out  output  WORLD_BITS signed  latched y to datapath.
REQ-013 SHALL have port poly_idx_out  output  $clog2(MAX_POLYS)  polygon selected for datapath vertex mux.
REQ-014 SHALL have port poly_valid_out  output  1  issue strobe for poly_idx_out.
REQ-015 SHALL have port dp_result_in  input  1  datapath inside/outside result.
REQ-016 SHALL have port res_valid_out  output  1  result available.
REQ-017 SHALL have port res_ready_in  input  1  consumer takes result.
REQ-018 SHALL have port hit_out  output  1  point inside at least one polygon.
REQ-019 SHALL have port hit_idx_out  output  $clog2(MAX_POLYS)  lowest index hit (0 if none).
REQ-020 SHALL have port busy_out  output  1  high in any state except IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-022 SHALL assert query_ready_out only in IDLE; accept on query_valid_in && query_ready_out, latching x_in, y_in into px_out, py_out and N = min(num_polys_in, MAX_POLYS).
REQ-023 SHALL hold px_out, py_out stable from accept until next accept.
REQ-024 SHALL, on accept with N=0, go IDLE->DONE next cycle with hit_out=0, hit_idx_out=0, no issue strobes.
REQ-025 SHALL, on accept with N>0, enter ISSUE and assert poly_valid_out for exactly N consecutive cycles with poly_idx_out = 0,1,...,N-1.
REQ-026 SHALL track issues in a PIP_LATENCY-deep valid/index shift register; dp_result_in is sampled only when the tracked valid emerges, PIP_LATENCY cycles after its issue.
REQ-027 SHALL go ISSUE->DRAIN after the issue of index N-1, and DRAIN->DONE on the cycle the result of index N-1 is sampled.
REQ-028 SHALL set hit accumulator on any sampled dp_result_in=1; hit_idx records the first (lowest) sampled hit index and is never overwritten by later hits.
REQ-029 SHALL ignore dp_result_in on cycles with no tracked valid emerging.
REQ-030 SHALL hold res_valid_out=1 with stable hit_out, hit_idx_out in DONE until res_ready_in=1, then return to IDLE next cycle.
REQ-031 SHALL allow a new accept no earlier than the cycle after DONE exit (no same-cycle result/accept overlap).
REQ-032 SHALL complete a query of N>0 with res_valid_out rising N+PIP_LATENCY cycles after the accept edge.
REQ-033 SHALL clear hit accumulator and hit_idx at each accept.

Reset
REQ-034 SHALL, on rst_n_in=0, immediately (asynchronously) enter IDLE and clear tracker, accumulators, poly_idx_out, px_out, py_out, hit_out, hit_idx_out to 0; poly_valid_out=0, res_valid_out=0, busy_out=0, query_ready_out=0 while reset asserted.
REQ-035 SHALL, after reset mid-query, emit no result for the aborted query and ignore in-flight dp_result_in values.
REQ-036 SHALL assert query_ready_out on the first clock edge after rst_n_in deasserts.

Verification
REQ-037 SHALL cover: N=3, dp_result_in=0 for all -> 3 strobes idx 0,1,2; res_valid_out at accept+7 (PIP_LATENCY=4); hit_out=0, hit_idx_out=0.
REQ-038 SHALL cover: N=5, results for idx 2 and 4 =1 -> hit_out=1, hit_idx_out=2.
REQ-039 SHALL cover: N=0 -> no strobes, res_valid_out next cycle, hit_out=0.
REQ-040 SHALL cover: num_polys_in=31 with MAX_POLYS=16 -> exactly 16 strobes, last idx 15.
REQ-041 SHALL cover: res_ready_in low 10 cycles in DONE -> outputs stable, query_ready_out=0, new query_valid_in not accepted until after handshake.
REQ-042 SHALL cover: rst_n_in pulsed low during DRAIN with dp_result_in=1 -> no res_valid_out; next query N=1 result 0 -> hit_out=0.
